// File: rtl/wb_stage_reg.sv
// Writeback stage: source select, load extract/extend, one-entry output register, retire counter.
// Latency: 1 cycle from accepted input beat to out_valid; one beat per cycle with out_ready high.
// Backpressure: in_ready = !out_valid || out_ready; held beat is stable while out_ready is low.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drops the held beat and any beat presented in the same cycle
//   in_valid/in_ready   upstream handshake
//   wb_sel              0 = ALU, 1 = MEM (extracted load), 2 = PC+4, 3 = IMM
//   alu_result, mem_rdata, pc_plus4, imm   candidate writeback sources
//   funct3, byte_off    load type and address bits [1:0]
//   rd_in, reg_write_in destination register and write request
//   out_valid/out_ready downstream handshake
//   write_data, rd_out, reg_write_out, misalign   registered beat
//   retire_cnt          count of beats accepted downstream (wraps)
//
// Optional: define WB_FWD_EN to add fwd_rs1/fwd_rs2 inputs and fwd_hit1/fwd_hit2
// outputs flagging that the held beat can forward write_data to a source operand.
// XLEN must be at least 32.

module wb_stage_reg #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       wb_sel,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       funct3,
    input  logic [1:0]       byte_off,
    input  logic [RA_W-1:0]  rd_in,
    input  logic             reg_write_in,
`ifdef WB_FWD_EN
    input  logic [RA_W-1:0]  fwd_rs1,
    input  logic [RA_W-1:0]  fwd_rs2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  write_data,
    output logic [RA_W-1:0]  rd_out,
    output logic             reg_write_out,
    output logic             misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic load_beat;
    logic retire;

    assign in_ready  = !out_valid || out_ready;
    assign load_beat = in_valid && in_ready && !flush;
    assign retire    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_word;
    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;

    always_comb begin
        ld_byte = 8'h00;
        case (byte_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
    end

    // Half lane is chosen by byte_off[1] only; byte_off[0] is a misalignment, not a lane.
    assign ld_half = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_word = mem_rdata[31:0];

    // Size casts of $signed operands sign-extend, plain operands zero-extend;
    // this also keeps the XLEN == 32 word case free of zero-width replications.
    always_comb begin
        ld_data     = '0;
        ld_misalign = 1'b0;
        case (funct3)
            F3_LB: begin
                ld_data = XLEN'($signed(ld_byte));
            end
            F3_LBU: begin
                ld_data = XLEN'(ld_byte);
            end
            F3_LH: begin
                ld_data     = XLEN'($signed(ld_half));
                ld_misalign = byte_off[0];
            end
            F3_LHU: begin
                ld_data     = XLEN'(ld_half);
                ld_misalign = byte_off[0];
            end
            F3_LW: begin
                ld_data     = XLEN'($signed(ld_word));
                ld_misalign = (byte_off != 2'd0);
            end
            default: begin
                // Reserved load encodings are reported through the misalign flag.
                ld_data     = '0;
                ld_misalign = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Source select and write qualification
    // ------------------------------------------------------------------
    logic [XLEN-1:0] nxt_data;
    logic            nxt_misalign;
    logic            nxt_reg_write;

    always_comb begin
        nxt_data     = '0;
        nxt_misalign = 1'b0;
        case (wb_sel)
            SEL_ALU: nxt_data = alu_result;
            SEL_MEM: begin
                nxt_misalign = ld_misalign;
                nxt_data     = ld_misalign ? '0 : ld_data;
            end
            SEL_PC4: nxt_data = pc_plus4;
            SEL_IMM: nxt_data = imm;
            default: nxt_data = '0;
        endcase
    end

    // Writes to x0 are suppressed here so the register file never sees them.
    assign nxt_reg_write = reg_write_in && (rd_in != '0) && !nxt_misalign;

    // ------------------------------------------------------------------
    // Output register and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            write_data    <= '0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            misalign      <= 1'b0;
            retire_cnt    <= '0;
        end else begin
            // A held beat accepted downstream in a flush cycle has already
            // been consumed, so it still counts.
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end

            if (flush) begin
                // Data and rd are left stale; out_valid and the write enable
                // are what make the slot inert.
                out_valid     <= 1'b0;
                reg_write_out <= 1'b0;
                misalign      <= 1'b0;
            end else if (load_beat) begin
                out_valid     <= 1'b1;
                write_data    <= nxt_data;
                rd_out        <= rd_in;
                reg_write_out <= nxt_reg_write;
                misalign      <= nxt_misalign;
            end else if (out_ready) begin
                out_valid     <= 1'b0;
            end
        end
    end

`ifdef WB_FWD_EN
    // ------------------------------------------------------------------
    // Operand forwarding hit detection (combinational on held beat)
    // ------------------------------------------------------------------
    assign fwd_hit1 = out_valid && reg_write_out && (rd_out == fwd_rs1) && (fwd_rs1 != '0);
    assign fwd_hit2 = out_valid && reg_write_out && (rd_out == fwd_rs2) && (fwd_rs2 != '0);
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg: driver pushes expected beats, monitor pops on output accept.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Stall, flush and reset cases manage the scoreboard explicitly.

module tb_wb_stage_reg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       wb_sel;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  mem_rdata;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  imm;
    logic [2:0]       funct3;
    logic [1:0]       byte_off;
    logic [RA_W-1:0]  rd_in;
    logic             reg_write_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  write_data;
    logic [RA_W-1:0]  rd_out;
    logic             reg_write_out;
    logic             misalign;
    logic [CNT_W-1:0] retire_cnt;
`ifdef WB_FWD_EN
    logic [RA_W-1:0]  fwd_rs1;
    logic [RA_W-1:0]  fwd_rs2;
    logic             fwd_hit1;
    logic             fwd_hit2;
`endif

    wb_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wb_sel        (wb_sel),
        .alu_result    (alu_result),
        .mem_rdata     (mem_rdata),
        .pc_plus4      (pc_plus4),
        .imm           (imm),
        .funct3        (funct3),
        .byte_off      (byte_off),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
`ifdef WB_FWD_EN
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .write_data    (write_data),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .misalign      (misalign),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_ret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a beat is consumed when out_valid && out_ready at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {59'd0, rd_out}, 64'h1f_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_data", {32'd0, write_data}, {32'd0, e.wd});
                chk("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                chk("reg_write_out", {63'd0, reg_write_out}, {63'd0, e.rw});
                chk("misalign", {63'd0, misalign}, {63'd0, e.mis});
                chk("retire_cnt", {32'd0, retire_cnt}, n_ret);
            end
            n_ret++;
        end
    end

    task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] rd, input logic rw);
        wb_sel       = sel;
        funct3       = f3;
        byte_off     = off;
        rd_in        = rd;
        reg_write_in = rw;
        in_valid     = 1'b1;
    endtask

    task automatic wait_accept(input exp_t e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 20 cycles");
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                        input logic [4:0] rd, input logic rw,
                        input logic [31:0] wd, input logic ew, input logic em);
        exp_t e;
        e = '{wd: wd, rd: rd, rw: ew, mis: em};
        drive(sel, f3, off, rd, rw);
        wait_accept(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !out_valid) return;
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        wb_sel       = 2'd0;
        alu_result   = 32'h0000_0011;
        mem_rdata    = 32'h80FF_7F01;
        pc_plus4     = 32'h0000_0104;
        imm          = 32'hABCD_E000;
        funct3       = 3'b000;
        byte_off     = 2'd0;
        rd_in        = 5'd0;
        reg_write_in = 1'b0;
`ifdef WB_FWD_EN
        fwd_rs1      = 5'd0;
        fwd_rs2      = 5'd0;
`endif
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_write_data", {32'd0, write_data}, 64'd0);
        chk("rst_retire_cnt", {32'd0, retire_cnt}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sources; funct3/byte_off set to values that would misalign a load.
        send(2'd0, 3'b111, 2'd1, 5'd1, 1'b1, 32'h0000_0011, 1'b1, 1'b0);
        send(2'd2, 3'b010, 2'd3, 5'd2, 1'b1, 32'h0000_0104, 1'b1, 1'b0);
        send(2'd3, 3'b001, 2'd1, 5'd3, 1'b1, 32'hABCD_E000, 1'b1, 1'b0);

        // Loads from 0x80FF7F01.
        send(2'd1, 3'b000, 2'd2, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(2'd1, 3'b000, 2'd1, 5'd4, 1'b1, 32'h0000_007F, 1'b1, 1'b0);
        send(2'd1, 3'b100, 2'd3, 5'd5, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
        send(2'd1, 3'b001, 2'd2, 5'd6, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0);
        send(2'd1, 3'b101, 2'd0, 5'd7, 1'b1, 32'h0000_7F01, 1'b1, 1'b0);
        send(2'd1, 3'b010, 2'd0, 5'd8, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0);

        // Misalignment, reserved encodings, x0 and no-write.
        send(2'd1, 3'b010, 2'd1, 5'd9,  1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send(2'd1, 3'b001, 2'd3, 5'd10, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send(2'd1, 3'b011, 2'd0, 5'd11, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send(2'd0, 3'b000, 2'd0, 5'd0,  1'b1, 32'h0000_0011, 1'b0, 1'b0);
        send(2'd2, 3'b000, 2'd0, 5'd12, 1'b0, 32'h0000_0104, 1'b0, 1'b0);
        drain();
        chk("retire_after_stream", {32'd0, retire_cnt}, 64'd14);

        // Backpressure: hold beat A, present B for 3 stalled cycles.
        out_ready = 1'b0;
        send(2'd3, 3'b000, 2'd0, 5'd13, 1'b1, 32'hABCD_E000, 1'b1, 1'b0);
        drive(2'd0, 3'b000, 2'd0, 5'd14, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_write_data", {32'd0, write_data}, 64'hABCD_E000);
            chk("stall_rd_out", {59'd0, rd_out}, 64'd13);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept('{wd: 32'h0000_0011, rd: 5'd14, rw: 1'b1, mis: 1'b0});
        drain();
        chk("retire_after_stall", {32'd0, retire_cnt}, 64'd16);

        // Flush of an incoming beat on an empty stage.
        flush = 1'b1;
        drive(2'd0, 3'b000, 2'd0, 5'd15, 1'b1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_reg_write", {63'd0, reg_write_out}, 64'd0);

        // Flush of a stalled held beat: dropped, not retired.
        out_ready = 1'b0;
        send(2'd0, 3'b000, 2'd0, 5'd5, 1'b1, 32'h0000_0011, 1'b1, 1'b0);
`ifdef WB_FWD_EN
        fwd_rs1 = 5'd5;
        fwd_rs2 = 5'd0;
        #1;
        chk("fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
        chk("fwd_hit2", {63'd0, fwd_hit2}, 64'd0);
`endif
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_held_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_held_reg_write", {63'd0, reg_write_out}, 64'd0);
        chk("flush_held_retire", {32'd0, retire_cnt}, 64'd16);
        out_ready = 1'b1;

        // Asynchronous reset while a beat is held under stall.
        out_ready = 1'b0;
        send(2'd2, 3'b000, 2'd0, 5'd6, 1'b1, 32'h0000_0104, 1'b1, 1'b0);
        held = write_data;
        chk("pre_reset_held", {32'd0, held}, 64'h104);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("areset_retire_cnt", {32'd0, retire_cnt}, 64'd0);
        chk("areset_reg_write", {63'd0, reg_write_out}, 64'd0);
        chk("areset_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        n_ret = 0;
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Counter restarts from zero after reset.
        send(2'd0, 3'b000, 2'd0, 5'd7, 1'b1, 32'h0000_0011, 1'b1, 1'b0);
        send(2'd3, 3'b000, 2'd0, 5'd8, 1'b1, 32'hABCD_E000, 1'b1, 1'b0);
        drain();
        chk("retire_after_reset", {32'd0, retire_cnt}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
- Registered, parametrised writeback stage for the pipelined RISC-V core.
- Selects one of four writeback sources: ALU result, load data, PC+4, or immediate.
- Sign- or zero-extends and aligns sub-word loads.
- Holds the result in a one-entry pipeline register with a valid/ready handshake, and keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width; must be >= 32.
RA_W, 5, register-address width.
CNT_W, 32, width of the retire counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous flush: drops the held entry and the incoming beat.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
wb_sel  in  2  source select: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM.
alu_result  in  XLEN  ALU output.
mem_rdata  in  XLEN  raw word returned by data memory.
pc_plus4  in  XLEN  link value.
imm  in  XLEN  U-type immediate.
funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
byte_off  in  2  load address bits [1:0].
rd_in  in  RA_W  destination register.
reg_write_in  in  1  instruction writes rd.
out_valid  out  1  held beat valid.
out_ready  in  1  register file / downstream accepts.
write_data  out  XLEN  registered writeback value.
rd_out  out  RA_W  registered destination.
reg_write_out  out  1  qualified write enable.
misalign  out  1  held load was misaligned.
retire_cnt  out  CNT_W  count of accepted output beats.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs clear.
  - out_valid = 0, write_data = 0, rd_out = 0, reg_write_out = 0, misalign = 0, retire_cnt = 0.
  - in_ready follows its formula, so it is 1 while out_valid = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load when in_valid && in_ready && !flush.
  - If no load occurs, out_valid clears when out_ready is high.
  - Held outputs stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from an accepted input to out_valid. With out_ready held high, throughput is one beat per cycle.
- Load extraction (wb_sel = 1): select lane mem_rdata[8*byte_off +: 8] for bytes, or mem_rdata[16*byte_off[1] +: 16] for halves.
  - LB and LH sign-extend to XLEN; LBU and LHU zero-extend.
  - LW takes mem_rdata[31:0], sign-extended to XLEN when XLEN > 32.
  - Reserved funct3 values (011, 110, 111) produce 0 and set misalign.
- Misalignment:
  - LH/LHU with byte_off[0] = 1 sets misalign.
  - LW with byte_off != 0 sets misalign.
  - When misalign is set: write_data = 0 and reg_write_out = 0.
- wb_sel values 0, 2 and 3 ignore funct3 and byte_off; misalign = 0 for these.
- reg_write_out = reg_write_in && (rd_in != 0) && !misalign, captured at load time.
- retire_cnt increments when out_valid && out_ready and wraps modulo 2^CNT_W.
- flush:
  - Takes priority over everything except reset.
  - Next cycle: out_valid = 0 and reg_write_out = 0. Data and rd registers may keep stale values.
  - A beat presented with flush is discarded.
  - If the held beat has out_ready high in the flush cycle, it still counts as retired.
- Reset mid-stall drops the held beat; the counter returns to 0.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, four extra ports:
  - fwd_rs1, fwd_rs2: in, RA_W each.
  - fwd_hit1, fwd_hit2: out, 1 each.
- fwd_hitN = out_valid && reg_write_out && (rd_out == fwd_rsN) && (fwd_rsN != 0). This is combinational; the forwarded value is write_data.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-stream with out_valid = 1 -> out_valid = 0, retire_cnt = 0, reg_write_out = 0 immediately, without waiting for a clock edge.
- Sources: wb_sel = 0/2/3 with alu_result = 0x11, pc_plus4 = 0x104, imm = 0xABCDE000, out_ready = 1 -> write_data equals each source one cycle later.
- Loads: mem_rdata = 0x80FF7F01.
  - LB byte_off = 2 -> 0xFFFFFFFF.
  - LBU byte_off = 3 -> 0x00000080.
  - LH byte_off = 2 -> 0xFFFF80FF.
  - LHU byte_off = 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Misalign/x0:
  - LW byte_off = 1 -> misalign = 1, reg_write_out = 0, write_data = 0.
  - rd_in = 0 with reg_write_in = 1 -> reg_write_out = 0.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable; then out_ready = 1 -> next beat loads on the following edge and retire_cnt increments by 1 per accept.
- Flush/forward: flush with in_valid = 1 -> out_valid = 0 next cycle. With WB_FWD_EN, rd_out = 5, fwd_rs1 = 5, fwd_rs2 = 0 -> fwd_hit1 = 1, fwd_hit2 = 0.
